// File: rtl/fs_command_sequencer.sv
// fs_command_sequencer
// Turns CPU-side commands (OPEN, READ, WRITE, DELETE) into control strobes for
// the file-backed filesystem block. OPEN streams the buffered name four chars
// per cycle, NUL-terminated. READ/WRITE/DELETE issue one-cycle strobes. Every
// command ends with a one-cycle response pulse.
//
// Ports:
//   CLOCK_50, reset           clock and synchronous active-high reset
//   cmd_valid/cmd_ready       command handshake (ready only in IDLE)
//   cmd_op/cmd_addr/cmd_wdata command opcode, word address, write data
//   name_wr/name_idx/name_word name buffer write port
//   rsp_valid/rsp_data/rsp_err one-cycle response
//   file_open                 a file is currently open
//   fs_filename               name stream to filesystem, 0 when idle
//   fs_rden/fs_wren/fs_del    one-cycle filesystem strobes
//   fs_address/fs_data        filesystem word address / write data
//   fs_q                      filesystem read data, valid cycle after fs_rden
module fs_command_sequencer #(
  parameter int NAME_WORDS = 8,
  parameter int IDX_W      = 3
) (
  input  logic             CLOCK_50,
  input  logic             reset,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [1:0]       cmd_op,
  input  logic [31:0]      cmd_addr,
  input  logic [31:0]      cmd_wdata,
  input  logic             name_wr,
  input  logic [IDX_W-1:0] name_idx,
  input  logic [31:0]      name_word,
  output logic             rsp_valid,
  output logic [31:0]      rsp_data,
  output logic             rsp_err,
  output logic             file_open,
  output logic [31:0]      fs_filename,
  output logic             fs_rden,
  output logic             fs_wren,
  output logic             fs_del,
  output logic [31:0]      fs_address,
  output logic [31:0]      fs_data,
  input  logic [31:0]      fs_q
);

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    STREAM    = 3'd1,
    RD_ISSUE  = 3'd2,
    RD_WAIT   = 3'd3,
    WR_ISSUE  = 3'd4,
    DEL_ISSUE = 3'd5,
    RESP      = 3'd6
  } state_t;

  localparam logic [1:0]       OP_OPEN   = 2'b00;
  localparam logic [1:0]       OP_READ   = 2'b01;
  localparam logic [1:0]       OP_WRITE  = 2'b10;
  localparam logic [1:0]       OP_DELETE = 2'b11;
  localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(NAME_WORDS - 1);
  localparam logic [IDX_W-1:0] IDX_ONE   = IDX_W'(1);

  // True when any of the four chars is NUL.
  function automatic logic has_nul(input logic [31:0] w);
    return (w[31:24] == 8'h00) || (w[23:16] == 8'h00) ||
           (w[15:8] == 8'h00) || (w[7:0] == 8'h00);
  endfunction

  // Zero every char that follows the first NUL in the word.
  function automatic logic [31:0] mask_after_nul(input logic [31:0] w);
    logic [31:0] m;
    m = w;
    if (w[31:24] == 8'h00) begin
      m[23:0] = 24'h0;
    end else if (w[23:16] == 8'h00) begin
      m[15:0] = 16'h0;
    end else if (w[15:8] == 8'h00) begin
      m[7:0] = 8'h0;
    end else begin
      m = w;
    end
    return m;
  endfunction

  state_t           state_r, state_s;
  logic [31:0]      name_buf_r [NAME_WORDS];
  logic [IDX_W-1:0] idx_r, idx_s, idx_inc_s;
  logic             cur_nul_r, cur_nul_s;
  logic             term_r, term_s;
  logic [31:0]      word0_eff_s, next_word_s;

  logic             cmd_ready_r, cmd_ready_s;
  logic             rsp_valid_r, rsp_valid_s;
  logic [31:0]      rsp_data_r, rsp_data_s;
  logic             rsp_err_r, rsp_err_s;
  logic             file_open_r, file_open_s;
  logic [31:0]      fs_filename_r, fs_filename_s;
  logic             fs_rden_r, fs_rden_s;
  logic             fs_wren_r, fs_wren_s;
  logic             fs_del_r, fs_del_s;
  logic [31:0]      fs_address_r, fs_address_s;
  logic [31:0]      fs_data_r, fs_data_s;

  assign cmd_ready   = cmd_ready_r;
  assign rsp_valid   = rsp_valid_r;
  assign rsp_data    = rsp_data_r;
  assign rsp_err     = rsp_err_r;
  assign file_open   = file_open_r;
  assign fs_filename = fs_filename_r;
  assign fs_rden     = fs_rden_r;
  assign fs_wren     = fs_wren_r;
  assign fs_del      = fs_del_r;
  assign fs_address  = fs_address_r;
  assign fs_data     = fs_data_r;

  // A name write landing with an OPEN accept must be seen by the stream.
  assign word0_eff_s = (name_wr && (name_idx == {IDX_W{1'b0}})) ? name_word : name_buf_r[0];
  assign idx_inc_s   = idx_r + IDX_ONE;
  assign next_word_s = name_buf_r[idx_inc_s];

  // Name buffer: cleared on reset, frozen while the name is being streamed.
  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      for (int i = 0; i < NAME_WORDS; i++) begin
        name_buf_r[i] <= 32'h0;
      end
    end else if (name_wr && (state_r != STREAM)) begin
      name_buf_r[name_idx] <= name_word;
    end
  end

  // State and registered outputs.
  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      state_r       <= IDLE;
      idx_r         <= {IDX_W{1'b0}};
      cur_nul_r     <= 1'b0;
      term_r        <= 1'b0;
      cmd_ready_r   <= 1'b0;
      rsp_valid_r   <= 1'b0;
      rsp_data_r    <= 32'h0;
      rsp_err_r     <= 1'b0;
      file_open_r   <= 1'b0;
      fs_filename_r <= 32'h0;
      fs_rden_r     <= 1'b0;
      fs_wren_r     <= 1'b0;
      fs_del_r      <= 1'b0;
      fs_address_r  <= 32'h0;
      fs_data_r     <= 32'h0;
    end else begin
      state_r       <= state_s;
      idx_r         <= idx_s;
      cur_nul_r     <= cur_nul_s;
      term_r        <= term_s;
      cmd_ready_r   <= cmd_ready_s;
      rsp_valid_r   <= rsp_valid_s;
      rsp_data_r    <= rsp_data_s;
      rsp_err_r     <= rsp_err_s;
      file_open_r   <= file_open_s;
      fs_filename_r <= fs_filename_s;
      fs_rden_r     <= fs_rden_s;
      fs_wren_r     <= fs_wren_s;
      fs_del_r      <= fs_del_s;
      fs_address_r  <= fs_address_s;
      fs_data_r     <= fs_data_s;
    end
  end

  // Next state and next output values; outputs are the values for the
  // cycle spent in the next state.
  always_comb begin
    state_s       = state_r;
    idx_s         = idx_r;
    cur_nul_s     = cur_nul_r;
    term_s        = term_r;
    file_open_s   = file_open_r;
    fs_filename_s = 32'h0;
    fs_rden_s     = 1'b0;
    fs_wren_s     = 1'b0;
    fs_del_s      = 1'b0;
    fs_address_s  = fs_address_r;
    fs_data_s     = fs_data_r;
    rsp_data_s    = 32'h0;
    rsp_err_s     = 1'b0;

    case (state_r)
      IDLE: begin
        if (cmd_valid && cmd_ready_r) begin
          case (cmd_op)
            OP_OPEN: begin
              if (word0_eff_s[31:24] == 8'h00) begin
                state_s   = RESP;
                rsp_err_s = 1'b1;
              end else begin
                state_s       = STREAM;
                idx_s         = {IDX_W{1'b0}};
                term_s        = 1'b0;
                fs_filename_s = mask_after_nul(word0_eff_s);
                cur_nul_s     = has_nul(word0_eff_s);
              end
            end
            OP_READ: begin
              if (file_open_r) begin
                state_s      = RD_ISSUE;
                fs_rden_s    = 1'b1;
                fs_address_s = cmd_addr;
              end else begin
                state_s   = RESP;
                rsp_err_s = 1'b1;
              end
            end
            OP_WRITE: begin
              if (file_open_r) begin
                state_s      = WR_ISSUE;
                fs_wren_s    = 1'b1;
                fs_address_s = cmd_addr;
                fs_data_s    = cmd_wdata;
              end else begin
                state_s   = RESP;
                rsp_err_s = 1'b1;
              end
            end
            OP_DELETE: begin
              if (file_open_r) begin
                state_s  = DEL_ISSUE;
                fs_del_s = 1'b1;
              end else begin
                state_s   = RESP;
                rsp_err_s = 1'b1;
              end
            end
            default: begin
              state_s   = RESP;
              rsp_err_s = 1'b1;
            end
          endcase
        end else begin
          state_s = IDLE;
        end
      end
      STREAM: begin
        // The word on the bus was the last one (had a NUL, or was the
        // all-zero terminator after a full buffer).
        if (term_r || cur_nul_r) begin
          state_s     = RESP;
          term_s      = 1'b0;
          file_open_s = 1'b1;
        end else if (idx_r == IDX_LAST) begin
          term_s = 1'b1;
        end else begin
          idx_s         = idx_inc_s;
          fs_filename_s = mask_after_nul(next_word_s);
          cur_nul_s     = has_nul(next_word_s);
        end
      end
      RD_ISSUE:  state_s = RD_WAIT;
      RD_WAIT: begin
        state_s    = RESP;
        rsp_data_s = fs_q;
      end
      WR_ISSUE:  state_s = RESP;
      DEL_ISSUE: begin
        state_s     = RESP;
        file_open_s = 1'b0;
      end
      RESP:      state_s = IDLE;
      default:   state_s = IDLE;
    endcase

    rsp_valid_s = (state_s == RESP);
    cmd_ready_s = (state_s == IDLE);
  end

endmodule
